rtc_mc_bus_ctrl: RTL

RTC_MC_BUS_CTRL -- requirements
Module: rtc_mc_bus_ctrl

---
 rtl/rtc_mc_bus_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rtc_mc_bus_ctrl.sv
// Host-to-register-bank bus controller: one read or write per request, with an
// ack timeout and an address-map check that rejects holes without touching the bank.
// Ports: i_clk/i_reset (sync, active-high); host side i_cs, i_rd_wr, i_host_addr,
//        i_host_wdata -> o_busy, o_done, o_err, o_host_rdata; bank side o_rd_en,
//        o_wr_en, o_addr, o_wdata <- i_rd_data, i_ack. All outputs are registered.
module rtc_mc_bus_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic        i_rd_wr,
    input  logic [5:0]  i_host_addr,
    input  logic [31:0] i_host_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_host_rdata,
    output logic        o_rd_en,
    output logic        o_wr_en,
    output logic [5:0]  o_addr,
    output logic [31:0] o_wdata,
    input  logic [31:0] i_rd_data,
    input  logic        i_ack
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    // Last wait cycle index; the timer starts at 0 on the first wait cycle.
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  timer, timer_nxt;
    logic        dir_rd, dir_rd_nxt;
    logic [5:0]  addr_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] rdata_nxt;
    logic        err_nxt;
    logic        addr_ok;

    // Valid map: 0x00-0x08 and 0x14-0x20.
    assign addr_ok = (i_host_addr <= 6'h08) ||
                     ((i_host_addr >= 6'h14) && (i_host_addr <= 6'h20));

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        dir_rd_nxt = dir_rd;
        addr_nxt   = o_addr;
        wdata_nxt  = o_wdata;
        rdata_nxt  = o_host_rdata;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (i_cs) begin
                    addr_nxt   = i_host_addr;
                    wdata_nxt  = i_host_wdata;
                    dir_rd_nxt = i_rd_wr;
                    timer_nxt  = 8'd0;
                    if (addr_ok) begin
                        state_nxt = i_rd_wr ? RD_WAIT : WR_WAIT;
                    end else begin
                        // Rejected before any channel enable is raised.
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                timer_nxt = timer + 8'd1;
                // Ack is checked first so a last-cycle ack still succeeds.
                if (i_ack) begin
                    rdata_nxt = i_rd_data;
                    state_nxt = DONE;
                end else if (timer == TMO_LAST) begin
                    rdata_nxt = 32'h0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end
            end
            WR_WAIT: begin
                timer_nxt = timer + 8'd1;
                if (i_ack) begin
                    state_nxt = DONE;
                end else if (timer == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the
    // state they describe rather than lagging it by a cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            timer        <= 8'd0;
            dir_rd       <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_host_rdata <= 32'h0;
            o_rd_en      <= 1'b0;
            o_wr_en      <= 1'b0;
            o_addr       <= 6'h0;
            o_wdata      <= 32'h0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            dir_rd       <= dir_rd_nxt;
            o_busy       <= (state_nxt != IDLE);
            o_done       <= (state_nxt == DONE);
            o_err        <= err_nxt;
            o_host_rdata <= rdata_nxt;
            o_rd_en      <= (state_nxt == RD_WAIT);
            o_wr_en      <= (state_nxt == WR_WAIT);
            o_addr       <= addr_nxt;
            o_wdata      <= wdata_nxt;
        end
    end

endmodule
